// File: rtl/core_pkg.sv
// Shared types and defaults for the next-PC sequencer.
//   pc_state_e         : sequencer FSM states (BOOT, RUN, HALT)
//   pc_src_e           : next-PC source chosen by the priority encoder
//   DEFAULT_ILEN_BYTES : default sequential fetch increment in bytes
package core_pkg;

    localparam int DEFAULT_ILEN_BYTES = 4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    typedef enum logic [2:0] {
        SEQ    = 3'd0,
        HOLD   = 3'd1,
        BRANCH = 3'd2,
        TRAP   = 3'd3,
        MRET   = 3'd4,
        BOOTV  = 3'd5
    } pc_src_e;

endpackage

// File: rtl/pc_src_prio.sv
// Combinational priority encoder for the next-PC source.
// Ports:
//   boot      in  sequencer is in its boot cycle; forces the reset vector
//   trap_req  in  exception/ecall (highest run-time priority)
//   mret_req  in  mret retiring
//   br_taken  in  EX-stage taken branch/jump
//   stall_req in  load-use stall (lowest; redirects override it)
//   src       out selected pc_src_e
module pc_src_prio
    import core_pkg::*;
(
    input  logic    boot,
    input  logic    trap_req,
    input  logic    mret_req,
    input  logic    br_taken,
    input  logic    stall_req,
    output pc_src_e src
);

    always_comb begin
        if (boot)           src = BOOTV;
        else if (trap_req)  src = TRAP;
        else if (mret_req)  src = MRET;
        else if (br_taken)  src = BRANCH;
        else if (stall_req) src = HOLD;
        else                src = SEQ;
    end

endmodule

// File: rtl/pc_ctrl.sv
// Next-PC sequencer for the pipelined RV32I core. Drives next_pc/pc_en of
// the PC register, issues IF/ID flushes on redirects and runs a
// BOOT/RUN/HALT FSM. Outputs are combinational from state and inputs, so
// the PC register updates on the same edge the decision is made.
// Ports:
//   clk, rst (sync, active-high)
//   pc_value        in  current PC (fetch address) from the PC register
//   stall_req       in  hold the PC
//   br_taken/br_target, trap_req, mret_req/mepc   redirect sources
//   halt_req/resume in  debug halt control
//   next_pc, pc_en  out PC register load value and enable
//   flush_if/id     out squash IF/ID and ID/EX registers
//   fetch_valid     out fetched instruction is architecturally valid
//   halted          out FSM is in HALT
// Optional (macro PC_CTRL_PERF_EN): stall_cnt, redirect_cnt saturating
// 32-bit event counters, cleared by rst.
module pc_ctrl
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_VEC  = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC   = 32'h0000_0100,
    parameter int          ILEN_BYTES = DEFAULT_ILEN_BYTES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_value,
    input  logic        stall_req,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        trap_req,
    input  logic        mret_req,
    input  logic [31:0] mepc,
    input  logic        halt_req,
    input  logic        resume,
    output logic [31:0] next_pc,
    output logic        pc_en,
    output logic        flush_if,
    output logic        flush_id,
    output logic        fetch_valid,
    output logic        halted
`ifdef PC_CTRL_PERF_EN
   ,output logic [31:0] stall_cnt,
    output logic [31:0] redirect_cnt
`endif
);

    pc_state_e   state, next_state;
    pc_src_e     src;
    logic [31:0] raw_pc;
    logic        flush;
    logic        redirect;
    logic        stall_hit;

    pc_src_prio u_prio (
        .boot      (state == BOOT),
        .trap_req  (trap_req),
        .mret_req  (mret_req),
        .br_taken  (br_taken),
        .stall_req (stall_req),
        .src       (src)
    );

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        next_state  = state;
        raw_pc      = pc_value;
        pc_en       = 1'b0;
        flush       = 1'b0;
        fetch_valid = 1'b0;
        halted      = 1'b0;
        redirect    = 1'b0;
        stall_hit   = 1'b0;

        if (rst) begin
            raw_pc = RESET_VEC;
            pc_en  = 1'b1;
            flush  = 1'b1;
        end else begin
            unique case (state)
                BOOT: begin
                    raw_pc     = RESET_VEC;
                    pc_en      = 1'b1;
                    flush      = 1'b1;
                    next_state = RUN;
                end
                RUN: begin
                    unique case (src)
                        TRAP:    begin raw_pc = TRAP_VEC;  redirect = 1'b1; end
                        MRET:    begin raw_pc = mepc;      redirect = 1'b1; end
                        BRANCH:  begin raw_pc = br_target; redirect = 1'b1; end
                        HOLD:    stall_hit = 1'b1;
                        default: raw_pc = pc_value + 32'(ILEN_BYTES);
                    endcase
                    pc_en = !stall_hit;
                    flush = redirect;
                    // A coincident redirect is taken first; halt follows once
                    // the redirect has been consumed and halt_req persists.
                    if (halt_req && !redirect) begin
                        raw_pc     = pc_value;
                        pc_en      = 1'b0;
                        next_state = HALT;
                    end
                    fetch_valid = !flush;
                end
                HALT: begin
                    halted = 1'b1;
                    if (resume) begin
                        pc_en      = 1'b1;
                        flush      = 1'b1;
                        next_state = RUN;
                    end
                end
                default: next_state = BOOT;
            endcase
        end
    end

    // Alignment faults are trapped upstream; the PC is always word-aligned.
    assign next_pc  = {raw_pc[31:2], 2'b00};
    assign flush_if = flush;
    assign flush_id = flush;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment only.
        if (rst) state <= BOOT;
        else     state <= next_state;
    end

`ifdef PC_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            if (stall_hit && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
            if (redirect && redirect_cnt != 32'hFFFF_FFFF)
                redirect_cnt <= redirect_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed self-checking bench for pc_ctrl. Inputs change 1ns after each
// rising edge; combinational outputs are sampled 1ns after that.
module tb_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_value, br_target, mepc;
    logic        stall_req, br_taken, trap_req, mret_req, halt_req, resume;
    logic [31:0] next_pc;
    logic        pc_en, flush_if, flush_id, fetch_valid, halted;
`ifdef PC_CTRL_PERF_EN
    logic [31:0] stall_cnt, redirect_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .pc_value    (pc_value),
        .stall_req   (stall_req),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .trap_req    (trap_req),
        .mret_req    (mret_req),
        .mepc        (mepc),
        .halt_req    (halt_req),
        .resume      (resume),
        .next_pc     (next_pc),
        .pc_en       (pc_en),
        .flush_if    (flush_if),
        .flush_id    (flush_id),
        .fetch_valid (fetch_valid),
        .halted      (halted)
`ifdef PC_CTRL_PERF_EN
       ,.stall_cnt    (stall_cnt),
        .redirect_cnt (redirect_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Checks every control output against one expected vector.
    task automatic expect_out(input string tag, input logic [31:0] npc, input logic en,
                              input logic fl, input logic fv, input logic hl);
        #1;
        check({tag, ".next_pc"}, next_pc, npc);
        check({tag, ".pc_en"}, 32'(pc_en), 32'(en));
        check({tag, ".flush_if"}, 32'(flush_if), 32'(fl));
        check({tag, ".flush_id"}, 32'(flush_id), 32'(fl));
        check({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(fv));
        check({tag, ".halted"}, 32'(halted), 32'(hl));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall_req = 0; br_taken = 0; trap_req = 0; mret_req = 0;
        halt_req = 0; resume = 0;
    endtask

    initial begin
        rst = 1'b1; idle_inputs();
        pc_value = 32'h0000_1234; br_target = 32'h0; mepc = 32'h0;

        // Reset held three cycles: reset-vector load with flushes.
        for (int i = 0; i < 3; i++) begin
            #1;
            expect_out("reset", 32'h0, 1, 1, 0, 0);
            tick();
        end
        rst = 1'b0;

        // BOOT cycle ignores a trap request.
        trap_req = 1;
        expect_out("boot", 32'h0, 1, 1, 0, 0);
        tick();
        trap_req = 0; pc_value = 32'h0;
        expect_out("run_seq0", 32'h4, 1, 0, 1, 0);
        tick();

        // Two-cycle stall, then release.
        pc_value = 32'h40; stall_req = 1;
        expect_out("stall1", 32'h40, 0, 0, 1, 0);
        tick();
        expect_out("stall2", 32'h40, 0, 0, 1, 0);
        tick();
        stall_req = 0;
        expect_out("stall_rel", 32'h44, 1, 0, 1, 0);
        tick();

        // Branch overrides a coincident stall.
        pc_value = 32'h80; br_taken = 1; br_target = 32'h200; stall_req = 1;
        expect_out("br_over_stall", 32'h200, 1, 1, 0, 0);
        tick();

        // All redirects together: trap wins; then mret alone.
        stall_req = 0; trap_req = 1; mret_req = 1; mepc = 32'h300;
        expect_out("trap_prio", 32'h100, 1, 1, 0, 0);
        tick();
        trap_req = 0; br_taken = 0;
        expect_out("mret", 32'h300, 1, 1, 0, 0);
        tick();
        mret_req = 0;

        // halt_req with a misaligned branch: branch taken first, low bits cleared.
        pc_value = 32'h50; halt_req = 1; br_taken = 1; br_target = 32'h207;
        expect_out("halt_br", 32'h204, 1, 1, 0, 0);
        tick();
        br_taken = 0;
        expect_out("halt_enter", 32'h50, 0, 0, 1, 0);
        tick();

        // In HALT: pipeline requests ignored.
        halt_req = 0; trap_req = 1; stall_req = 1; br_taken = 1;
        expect_out("halted", 32'h50, 0, 0, 0, 1);
        tick();
        idle_inputs(); resume = 1;
        expect_out("resume", 32'h50, 1, 1, 0, 1);
        tick();

        // Back in RUN: resume ignored, 32-bit wrap of sequential fetch.
        pc_value = 32'hFFFF_FFFC;
        expect_out("wrap", 32'h0, 1, 0, 1, 0);
`ifdef PC_CTRL_PERF_EN
        check("stall_cnt", stall_cnt, 32'd2);
        check("redirect_cnt", redirect_cnt, 32'd4);
`endif
        tick();
        resume = 0;

        // Reset mid-operation discards a pending redirect.
        rst = 1; br_taken = 1; br_target = 32'h400;
        expect_out("mid_reset", 32'h0, 1, 1, 0, 0);
        tick();
        rst = 0;
        expect_out("reboot", 32'h0, 1, 1, 0, 0);
`ifdef PC_CTRL_PERF_EN
        check("stall_cnt_clr", stall_cnt, 32'd0);
        check("redirect_cnt_clr", redirect_cnt, 32'd0);
`endif
        tick();
        expect_out("post_boot_br", 32'h400, 1, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
